// File: rtl/palette_pkg.sv
// Shared types and constants for the palette index encoder: colour struct,
// palette depth, distance width, default palette contents and FSM states.
package palette_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam int PAL_DEPTH = 16;
  localparam int DIST_W    = 10;
  localparam int IDX_W     = 4;

  localparam rgb12_t DEFAULT_PALETTE [0:PAL_DEPTH-1] = '{
    12'h332, 12'h863, 12'hCCA, 12'h000, 12'h887, 12'h544, 12'h210, 12'h655,
    12'h642, 12'hEEC, 12'h443, 12'h963, 12'h221, 12'h776, 12'hA98, 12'h852
  };

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/palette_dist.sv
// Combinational squared Euclidean distance between two 12-bit RGB colours.
// Maximum result is 3*15^2 = 675, so DIST_W bits never overflow.
module palette_dist
  import palette_pkg::*;
(
  input  rgb12_t              colour_a_i,
  input  rgb12_t              colour_b_i,
  output logic [DIST_W-1:0]   dist_o
);

  logic [3:0] ch_a [3];
  logic [3:0] ch_b [3];
  logic [7:0] sq   [3];

  assign ch_a[0] = colour_a_i.r;
  assign ch_a[1] = colour_a_i.g;
  assign ch_a[2] = colour_a_i.b;
  assign ch_b[0] = colour_b_i.r;
  assign ch_b[1] = colour_b_i.g;
  assign ch_b[2] = colour_b_i.b;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic signed [4:0] diff;
      logic [3:0]        mag;
      assign diff = $signed({1'b0, ch_a[gi]}) - $signed({1'b0, ch_b[gi]});
      // Magnitude of the signed difference; squaring the magnitude keeps the product unsigned.
      assign mag    = diff[4] ? (~diff[3:0] + 4'd1) : diff[3:0];
      assign sq[gi] = {4'b0, mag} * {4'b0, mag};
    end
  endgenerate

  assign dist_o = DIST_W'(sq[0]) + DIST_W'(sq[1]) + DIST_W'(sq[2]);

endmodule

// File: rtl/palette_index_encoder.sv
// Nearest-palette-entry encoder: scans one palette entry per clock and returns
// the lowest index with minimum squared distance. Palette is writable in IDLE.
module palette_index_encoder
  import palette_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic [3:0]        in_red,
  input  logic [3:0]        in_green,
  input  logic [3:0]        in_blue,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [DIST_W-1:0] out_dist,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_waddr,
  input  logic [11:0]       pal_wdata,
  output logic              pal_wready
);

  state_t              state_q;
  logic [IDX_W-1:0]    cnt_q;
  rgb12_t              colour_q;
  logic [DIST_W-1:0]   best_dist_q, best_dist_d;
  logic [IDX_W-1:0]    best_idx_q, best_idx_d;
  logic                out_valid_q;
  logic [IDX_W-1:0]    out_index_q;
  logic [DIST_W-1:0]   out_dist_q;
  rgb12_t              palette_q [PAL_DEPTH];
  logic [DIST_W-1:0]   cand_dist;
  logic                pal_wr_en;

  assign pal_wr_en = pal_we && (state_q == IDLE);

  generate
    for (genvar gi = 0; gi < PAL_DEPTH; gi++) begin : g_pal
      always_ff @(posedge Clk) begin
        if (Reset) begin
          palette_q[gi] <= DEFAULT_PALETTE[gi];
        end else if (pal_wr_en && (pal_waddr == IDX_W'(gi))) begin
          palette_q[gi] <= pal_wdata;
        end
      end
    end
  endgenerate

  palette_dist u_dist (
    .colour_a_i (colour_q),
    .colour_b_i (palette_q[cnt_q]),
    .dist_o     (cand_dist)
  );

  // Strict less-than keeps the earlier (lower) index on ties.
  always_comb begin
    best_dist_d = best_dist_q;
    best_idx_d  = best_idx_q;
    if (cand_dist < best_dist_q) begin
      best_dist_d = cand_dist;
      best_idx_d  = cnt_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      colour_q    <= '0;
      best_dist_q <= '1;
      best_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_dist_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            colour_q    <= {in_red, in_green, in_blue};
            cnt_q       <= '0;
            best_dist_q <= '1;
            best_idx_q  <= '0;
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          best_dist_q <= best_dist_d;
          best_idx_q  <= best_idx_d;
          cnt_q       <= cnt_q + 1'b1;
          if (cnt_q == IDX_W'(PAL_DEPTH - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_index_q <= best_idx_d;
            out_dist_q  <= best_dist_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign pal_wready = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign out_index  = out_index_q;
  assign out_dist   = out_dist_q;

endmodule

// File: tb/tb_palette_index_encoder.sv
// Directed bench for palette_index_encoder: exact match, tie-break, backpressure,
// palette writes, mid-scan reset and back-to-back throughput.
module tb_palette_index_encoder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic [3:0]  in_red, in_green, in_blue;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic [9:0]  out_dist;
  logic        pal_we;
  logic [3:0]  pal_waddr;
  logic [11:0] pal_wdata;
  logic        pal_wready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  palette_index_encoder dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_red     (in_red),
    .in_green   (in_green),
    .in_blue    (in_blue),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_dist   (out_dist),
    .pal_we     (pal_we),
    .pal_waddr  (pal_waddr),
    .pal_wdata  (pal_wdata),
    .pal_wready (pal_wready)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE. Returns at the negedge where out_valid is first seen;
  // with out_ready=1 it steps one more cycle so the caller is back in IDLE.
  task automatic run_search(input string tag, input logic [11:0] colour,
                            input logic [3:0] exp_idx, input logic [9:0] exp_dist,
                            input bit scan_write, output int accept_cyc);
    int k;
    check({tag, " in_ready"}, 16'(in_ready), 16'd1);
    in_valid = 1'b1;
    {in_red, in_green, in_blue} = colour;
    @(negedge Clk);
    accept_cyc = cyc;
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 40) begin
      if (scan_write) begin
        pal_we = 1'b1; pal_waddr = 4'd9; pal_wdata = 12'h000;
      end
      @(negedge Clk);
      k++;
      if (scan_write && k == 3) check({tag, " pal_wready scan"}, 16'(pal_wready), 16'd0);
    end
    pal_we = 1'b0;
    check({tag, " latency"}, 16'(k - 1), 16'd16);
    check({tag, " out_index"}, 16'(out_index), 16'(exp_idx));
    check({tag, " out_dist"}, 16'(out_dist), 16'(exp_dist));
    $display("search %s colour=%03h -> index=%0d dist=%0d", tag, colour, out_index, out_dist);
    if (out_ready) @(negedge Clk);
  endtask

  int acc_a, acc_b, seen_valid;

  initial begin
    Reset = 1'b1; in_valid = 1'b0; in_red = '0; in_green = '0; in_blue = '0;
    out_ready = 1'b1; pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    check("rst out_valid", 16'(out_valid), 16'd0);
    check("rst out_index", 16'(out_index), 16'd0);
    check("rst out_dist", 16'(out_dist), 16'd0);
    check("rst pal_wready", 16'(pal_wready), 16'd1);

    // 1: exact match
    run_search("exact", 12'hCCA, 4'd2, 10'd0, 1'b0, acc_a);
    // 2: tie between entries 1 and 15
    run_search("tie", 12'h853, 4'd1, 10'd1, 1'b0, acc_a);

    // 3: far colour with backpressure; in_valid in DONE must be ignored
    out_ready = 1'b0;
    run_search("far", 12'hFFF, 4'd9, 10'd11, 1'b0, acc_a);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; {in_red, in_green, in_blue} = 12'h000;
      @(negedge Clk);
      check("bp out_valid", 16'(out_valid), 16'd1);
      check("bp out_index", 16'(out_index), 16'd9);
      check("bp out_dist", 16'(out_dist), 16'd11);
      check("bp in_ready", 16'(in_ready), 16'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge Clk);
    check("bp release out_valid", 16'(out_valid), 16'd0);
    check("bp release in_ready", 16'(in_ready), 16'd1);

    // 4: palette write in IDLE, then dropped write during SCAN
    pal_we = 1'b1; pal_waddr = 4'd0; pal_wdata = 12'hFFF;
    check("wr pal_wready", 16'(pal_wready), 16'd1);
    @(negedge Clk);
    pal_we = 1'b0;
    run_search("wr0", 12'hFFF, 4'd0, 10'd0, 1'b0, acc_a);
    run_search("wrscan", 12'hEEC, 4'd9, 10'd0, 1'b1, acc_a);
    run_search("wrkept", 12'hEEC, 4'd9, 10'd0, 1'b0, acc_a);

    // 5: reset 7 cycles after accept
    in_valid = 1'b1; {in_red, in_green, in_blue} = 12'h332;
    @(negedge Clk);
    in_valid = 1'b0;
    repeat (6) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("mid rst in_ready", 16'(in_ready), 16'd1);
    check("mid rst out_valid", 16'(out_valid), 16'd0);
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (out_valid) seen_valid++;
    end
    check("mid rst no pulse", 16'(seen_valid), 16'd0);
    run_search("restored", 12'h332, 4'd0, 10'd0, 1'b0, acc_a);

    // 6: back-to-back accepts with out_ready tied high
    run_search("b2b0", 12'h000, 4'd3, 10'd0, 1'b0, acc_a);
    run_search("b2b1", 12'h100, 4'd3, 10'd1, 1'b0, acc_b);
    check("b2b interval", 16'(acc_b - acc_a), 16'd18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/palette_index_encoder.md
# palette_index_encoder

Reverse direction of the 4-bit palette lookup. Takes a 12-bit RGB colour and returns the 4-bit index of the nearest entry in a 16-entry palette, using squared Euclidean distance. The palettizer path uses it to convert live or sprite-source colours into indices before they are stored in index RAM; the existing palette ROMs then decode those indices back to RGB at scan-out. The block uses an iterative scan, one palette entry per clock, and holds a writable copy of the palette.

## Interface
- No parameters. Depth (16) and colour width (4 bits per channel) are fixed by `palette_pkg`.
- `Clk` input, 1 bit: the single clock.
- `Reset` input, 1 bit: synchronous, active-high.
- `in_valid` input, 1 bit: the colour on `in_red`/`in_green`/`in_blue` is valid.
- `in_red`, `in_green`, `in_blue` inputs, 4 bits each: colour to encode.
- `in_ready` output, 1 bit: the block accepts a colour this cycle.
- `out_valid` output, 1 bit: the result is valid.
- `out_ready` input, 1 bit: the consumer accepts the result.
- `out_index` output, 4 bits: index of the nearest palette entry.
- `out_dist` output, 10 bits: squared distance to that entry.
- `pal_we` input, 1 bit: palette write strobe.
- `pal_waddr` input, 4 bits: palette entry to write.
- `pal_wdata` input, 12 bits: new entry value, packed as {R,G,B}.
- `pal_wready` output, 1 bit: a palette write is accepted this cycle.

## Operation
- **States:** IDLE, SCAN, DONE. All registers, the palette included, update only on the rising edge of `Clk`.
- **IDLE**
  - `in_ready`=1, `pal_wready`=1.
  - When `in_valid`=1: latch the colour, set `cnt`=0, `best_dist`=10'h3FF, `best_idx`=0, and go to SCAN.
- **SCAN**
  - Each cycle computes d = (R−Pr)² + (G−Pg)² + (B−Pb)² against `palette[cnt]`.
    - Each difference is a 5-bit signed value; each square is 8 bits unsigned (max 225).
    - The sum is 10 bits (max 675), so it never overflows.
  - If d < `best_dist` (strict less-than), load `best_dist`=d and `best_idx`=`cnt`. On a tie the lowest index wins.
  - `cnt` increments. On the edge that evaluates `cnt`=15, go to DONE and register `out_index`/`out_dist` from the final best values. The entry-15 comparison is included.
  - `cnt` is 4 bits and wraps from 15 to 0. The wrap is not observable because the state leaves SCAN at the same edge.
- **DONE**
  - `out_valid`=1. `out_index` and `out_dist` are held stable.
  - When `out_ready`=1: go to IDLE and drop `out_valid`.
- **Handshakes**
  - `in_ready`=0 in SCAN and DONE. An asserted `in_valid` is ignored there and is not queued.
  - `in_valid` and `out_ready` are don't-care outside the states that sample them.
- **Palette writes**
  - A write is accepted only when `pal_we`=1 and state=IDLE; `pal_wready` is high in IDLE only.
  - `pal_we` in SCAN or DONE is dropped, not queued, so the palette is stable for a whole search.
  - If a write and `in_valid` arrive in the same IDLE cycle, both are taken. The search starts the next cycle and sees the new value.
- **Reset**
  - Reset values: state=IDLE, `out_valid`=0, `out_index`=0, `out_dist`=0, `cnt`=0.
  - Reloads the default palette.
  - Reset in the middle of a SCAN or DONE abandons the search; no `out_valid` pulse is produced.
- **Default palette**, indices 0–15, {R,G,B}:
  - 0–7: 332, 863, CCA, 000, 887, 544, 210, 655
  - 8–15: 642, EEC, 443, 963, 221, 776, A98, 852

## Timing
- In the cycles below, the accept edge is E0.
- E0: `in_valid`=1 and `in_ready`=1; the colour is accepted at this edge.
- E1 to E16: entries 0 to 15 are evaluated in order.
- `out_valid` is 1 from just after E16, i.e. 16 cycles after accept.
- With `out_ready` tied high:
  - the block returns to IDLE at E17;
  - the next colour can be accepted at E18;
  - minimum initiation interval is 18 cycles.
- `out_valid`, `out_index`, `out_dist` and `pal_wready` come directly from registers or state decode. None of them is a combinational function of `in_valid` or `out_ready`.

## Structure
- **`palette_pkg`** contains:
  - `rgb12_t`, a packed struct of three 4-bit fields;
  - `PAL_DEPTH`=16 and `DIST_W`=10;
  - `DEFAULT_PALETTE`, a `[0:15]` array of `rgb12_t`;
  - the `state_t` enum (IDLE, SCAN, DONE).
- **`palette_dist`**: one combinational sub-module. Inputs are two `rgb12_t`; output is the `DIST_W`-bit squared distance.
- The top level holds the FSM, counter, best-value registers and palette register file.

## Test plan
1. **Exact match:** after reset, input {C,C,A}. Expect `out_index`=2, `out_dist`=0, with `out_valid` rising 16 cycles after accept.
2. **Tie-break:** input {8,5,3}, which is distance 1 from both entry 1 and entry 15. Expect `out_index`=1, `out_dist`=1.
3. **Far colour and backpressure:**
   - Input {F,F,F}. Expect `out_index`=9, `out_dist`=11.
   - Hold `out_ready`=0 for 5 cycles: outputs stay stable and `in_ready`=0.
   - Assert `in_valid` in DONE: it is ignored.
4. **Palette write:**
   - In IDLE write entry 0 = FFF, then input {F,F,F}. Expect index 0, dist 0.
   - Assert `pal_we` (entry 9 = 000) during SCAN: it is dropped; a later input {E,E,C} still returns index 9, dist 0.
5. **Reset mid-scan:** assert `Reset` 7 cycles after accept. Expect no `out_valid`, IDLE the next cycle, and the default palette restored (entry 0 reads back as 332 via input {3,3,2} → index 0).
6. **Back-to-back:** with `out_ready`=1, input {0,0,0} then {1,0,0}. Expect index 3 dist 0, then index 3 dist 1, with the accepts 18 cycles apart.
